// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel state encoding
// and synchronizer depth.
package debounce_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: 2-flop synchronizer, stability FSM and counter,
// registered level output with single-cycle edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A reverting sample always wins over the completion check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch/button conditioner: WIDTH independent debounced
// levels with rise/fall pulses, all in the clk_50MHz domain.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk_50MHz (clk_50MHz),
      .reset     (reset),
      .raw_in    (raw_in[i]),
      .level_out (level_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized + directed bench for switch_debouncer against a run-length
// reference model (a level flips after STABLE+1 consecutive differing samples).
module tb_switch_debouncer;

  localparam int unsigned WIDTH  = 2;
  localparam int unsigned STABLE = 4;

  logic             clk_50MHz = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out, rise_pulse, fall_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] dly[$];
  int               run[WIDTH];
  logic [WIDTH-1:0] m_lvl, m_rise, m_fall;
  logic             saw_cross;

  switch_debouncer #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    dly.delete();
    dly.push_back('0);
    dly.push_back('0);
    for (int i = 0; i < int'(WIDTH); i++) run[i] = 0;
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  // Input seen by the debouncer at this edge is the raw value from two edges ago.
  task automatic model_edge(input logic [WIDTH-1:0] raw);
    logic [WIDTH-1:0] s;
    s = dly.pop_front();
    dly.push_back(raw);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == int'(STABLE) + 1) begin
          m_lvl[i] = s[i];
          if (s[i]) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("level", level_out, m_lvl);
    chk("rise", rise_pulse, m_rise);
    chk("fall", fall_pulse, m_fall);
    chk("excl", rise_pulse & fall_pulse, '0);
    if (rise_pulse == 2'b01 && fall_pulse == 2'b10) saw_cross = 1'b1;
  endtask

  task automatic step(input logic [WIDTH-1:0] raw_next);
    raw_in = raw_next;
    @(posedge clk_50MHz);
    model_edge(raw_in);
    #1;
    check_outputs();
  endtask

  // Asserted mid-cycle: outputs must clear without waiting for an edge.
  task automatic apply_reset(input int edges);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    for (int e = 0; e < edges; e++) begin
      @(posedge clk_50MHz);
      #1;
      check_outputs();
    end
    reset = 1'b0;
  endtask

  initial begin
    int hold[WIDTH];
    logic [WIDTH-1:0] r;
    saw_cross = 1'b0;
    raw_in = 2'b11;
    reset  = 1'b1;
    model_reset();

    // Switches held high through reset release: rise exactly at edge 6.
    apply_reset(3);
    for (int i = 0; i < 10; i++) begin
      step(2'b11);
      if (i == 5) chk("rst_lvl_e5", level_out, 2'b00);
      if (i == 6) chk("rst_rise_e6", rise_pulse, 2'b11);
      if (i == 7) chk("rst_rise_e7", rise_pulse, 2'b00);
    end

    // Back to a quiet low state, then bounce channel 0.
    raw_in = 2'b00;
    apply_reset(2);
    for (int i = 0; i < 4; i++) step(2'b00);
    for (int i = 0; i < 40; i++) step(((i / 2) % 2 == 0) ? 2'b01 : 2'b00);
    for (int i = 0; i < 4; i++) step(2'b00);
    chk("bounce_lvl", level_out, 2'b00);

    // Clean press and release on channel 0.
    for (int i = 0; i < 20; i++) step(2'b01);
    chk("press_lvl", level_out, 2'b01);
    for (int i = 0; i < 20; i++) step(2'b00);
    chk("release_lvl", level_out, 2'b00);

    // Channel 1: 4 stable samples abort, 5 accept.
    for (int i = 0; i < 4; i++) step(2'b10);
    for (int i = 0; i < 8; i++) step(2'b00);
    chk("late_abort", level_out, 2'b00);
    for (int i = 0; i < 5; i++) step(2'b10);
    for (int i = 0; i < 2; i++) step(2'b00);
    chk("hold5_lvl", level_out, 2'b10);

    // Channel 0 rises while channel 1 falls on the same edge.
    for (int i = 0; i < 8; i++) step(2'b10);
    saw_cross = 1'b0;
    for (int i = 0; i < 10; i++) step(2'b01);
    chk("cross_seen", 2'(saw_cross), 2'b01);
    chk("cross_lvl", level_out, 2'b01);

    // Reset while channel 0 is mid-count, then full latency again.
    raw_in = 2'b00;
    apply_reset(1);
    for (int i = 0; i < 4; i++) step(2'b00);
    for (int i = 0; i < 5; i++) step(2'b01);
    apply_reset(2);
    for (int i = 0; i < 10; i++) begin
      step(2'b01);
      if (i == 5) chk("midrst_e5", level_out, 2'b00);
      if (i == 6) chk("midrst_e6", rise_pulse, 2'b01);
    end

    // Random holds of varied length on both channels, occasional resets.
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (hold[i] == 0) begin
          r[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 9));
        end
        hold[i]--;
      end
      if ($urandom_range(0, 499) == 0) apply_reset(int'($urandom_range(1, 3)));
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Upstream conditioning stage for the JK flip-flop and clock-divider path. It takes raw slide-switch and push-button levels (J, K, reset-request buttons) and produces clean, glitch-free levels plus single-cycle edge pulses.
- Each channel is first passed through a 2-flop synchronizer into the 50 MHz domain.
- It is then debounced by a per-channel stability counter.
- Outputs feed the flip-flop data inputs directly.

Parameters:
WIDTH, 2, number of independent input channels (J, K by default)
STABLE_CYCLES, 1_000_000, consecutive cycles the synchronized input must hold a new value before it is accepted (20 ms at 50 MHz); legal range >= 1
CNT_W, $clog2(STABLE_CYCLES+1), counter width (derived; not overridden)

Ports:
clk_50MHz  input  1  single system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
raw_in  input  WIDTH  raw, bouncing, asynchronous switch/button levels
level_out  output  WIDTH  debounced level per channel
rise_pulse  output  WIDTH  one-cycle high when level_out[i] goes 0->1
fall_pulse  output  WIDTH  one-cycle high when level_out[i] goes 1->0

Behaviour:
- Interface: one clock, clk_50MHz. Reset is asynchronous and active-high.
- Reset:
  - sync flops, level_out, rise_pulse, fall_pulse, and counters all clear to 0 immediately.
  - Every channel's state is IDLE_LOW.
  - Reset asserted mid-count discards the count; no pulse is emitted.
- Synchronizer: s[i] = raw_in[i] delayed through 2 flops.
  - Only s[i] is used internally.
  - raw_in never touches other logic.
- Per-channel FSM, states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW:
  - IDLE_LOW: if s=1, go to WAIT_HIGH with cnt<=0; else stay.
  - WAIT_HIGH:
    - if s=0, go to IDLE_LOW (bounce abort; no output change, no pulse);
    - else if cnt==STABLE_CYCLES-1, go to IDLE_HIGH with level_out<=1 and rise_pulse<=1;
    - else cnt<=cnt+1.
  - IDLE_HIGH and WAIT_LOW: mirror image of the above (s=0 starts WAIT_LOW; completion sets level_out<=0, fall_pulse<=1).
- Latency:
  - If raw_in is first captured high at edge k and stays high, s=1 after edge k+1.
  - level_out rises after edge k+2+STABLE_CYCLES.
  - With STABLE_CYCLES=4, that is edge k+6.
- Pulses:
  - rise_pulse and fall_pulse are registered and asserted in the same cycle level_out changes.
  - Exactly one cycle wide; deasserted on every other cycle.
  - rise_pulse and fall_pulse are never high together on one channel.
- Boundary cases:
  - Abort at cnt==STABLE_CYCLES-1 with s reverting: no change.
  - A reversal in the exact completion cycle is treated as an abort (the s check has priority over the count check).
  - The counter never exceeds STABLE_CYCLES-1 and never wraps.
  - STABLE_CYCLES=1 accepts a value held for 2 consecutive synchronized samples.
- Channels are fully independent; simultaneous transitions on several channels are handled in parallel.
- A switch held high through reset release yields a normal rise after the full latency.

Decomposition:
- Shared package debounce_pkg holds:
  - the 2-bit state encoding constants IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3;
  - the SYNC_STAGES=2 constant.
- Sub-module debounce_channel (synchronizer + FSM + counter, one bit) is instantiated WIDTH times by a generate loop in switch_debouncer.
- The top-level board wrapper connects level_out[0]/[1] to the flip-flop J/K inputs.

Test Plan (WIDTH=2, STABLE_CYCLES=4):
- Reset behaviour:
  - Stimulus: reset=1 with raw_in=2'b11; release at edge 0 and hold.
  - Required: all outputs 0 during reset; level_out=2'b11 after edge 6; rise_pulse=2'b11 only in cycle 6.
- Bounce rejection:
  - Stimulus: raw_in[0] toggles every 2 cycles for 40 cycles.
  - Required: level_out[0] stays 0; no pulses.
- Clean press and release:
  - Stimulus: raw_in[0] set high (captured at edge 10), then low (captured at edge 30).
  - Required: level_out[0]=1 after edge 16 with rise_pulse[0] one cycle; level_out[0]=0 after edge 36 with fall_pulse[0] one cycle.
- Late abort:
  - Stimulus: s[1] high for exactly 4 cycles, then low.
  - Required: no change and no pulse. A 5-cycle hold must produce the change.
- Reset mid-count:
  - Stimulus: assert reset while channel 0 is in WAIT_HIGH at cnt=2.
  - Required: immediate clear; no pulse. After release, the full 6-cycle latency applies again.
- Independent channels:
  - Stimulus: channel 0 rises while channel 1 falls in the same cycle.
  - Required: rise_pulse=2'b01 and fall_pulse=2'b10 in the same cycle.
